pool_window_addr_gen: RTL and testbench

- Parametrised read-address generator for a convolution-layer output memory feeding a pooling stage.
- For every pooling window it issues all POOL*POOL tap addresses in parallel, walking columns, then rows, then channels.
- Adds a start/done handshake, a consumer stall (ready), a programmable start-up latency and multi-channel traversal.
- Sits between the conv output RAM and the max-pool datapath; one window per accepted beat.

---
 rtl/pool_window_addr_gen.sv | 197 +++++++++++++++++++
 tb/tb_pool_window_addr_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pool_window_addr_gen.sv
// pool_window_addr_gen
//   Read-address generator for a conv output RAM that feeds a max-pool stage.
//   Each beat presents all POOL*POOL tap addresses of one pooling window.
//   Windows are walked column first, then row, then channel. Channel planes
//   are stored back to back.
//
// Ports
//   clk      clock; all state changes on the falling edge
//   reset    asynchronous, active-low reset
//   start    one-cycle pulse that begins a full traversal (honoured in IDLE/DONE only)
//   ready    consumer accepts the current window when valid & ready
//   addr     tap addresses; tap k = i*POOL+j sits at [k*ADDR_W +: ADDR_W]
//   valid    addr holds a window
//   out_row  pooled-output row of the current window
//   out_col  pooled-output column of the current window
//   out_ch   channel of the current window
//   busy     high from the accepted start until the last window is taken
//   done     level, high after the final window is accepted, cleared by start
//
// Addresses wrap modulo 2^ADDR_W. Size ADDR_W to hold CHANNELS*IMG_W*IMG_H-1
// if wrapping is not wanted.

// One tap: the window base plus a constant in-window offset.
module pool_window_tap #(
    parameter int ADDR_W = 9,
    parameter int OFFSET = 0
) (
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] tap
);
    assign tap = base + ADDR_W'(OFFSET);
endmodule

module pool_window_addr_gen #(
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int POOL     = 2,
    parameter int STRIDE   = 2,
    parameter int CHANNELS = 1,
    parameter int LEAD     = 0,
    parameter int ADDR_W   = 9,
    localparam int OUT_W   = (IMG_W - POOL) / STRIDE + 1,
    localparam int OUT_H   = (IMG_H - POOL) / STRIDE + 1,
    localparam int COL_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int ROW_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CH_W    = $clog2(CHANNELS) + 1,
    localparam int TAPS    = POOL * POOL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     ready,
    output logic [TAPS*ADDR_W-1:0]   addr,
    output logic                     valid,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    output logic                     done
);

    // Base-address steps; all constants, so the per-beat path is adders only.
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(STRIDE);
    // From the last column of a row to column 0 of the next window row.
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(STRIDE * IMG_W - (OUT_W - 1) * STRIDE);
    localparam logic [ADDR_W-1:0] PLANE     = ADDR_W'(IMG_W * IMG_H);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT_H - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [3:0]        LEAD_LAST = 4'(LEAD - 1);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN, S_DONE} state_t;

    state_t                   state;
    logic [3:0]               lead_cnt;
    logic [ADDR_W-1:0]        base;      // tap (0,0) of the current window
    logic [ADDR_W-1:0]        ch_base;   // start of the current channel plane

    logic                     col_last, row_last, ch_last, win_last;
    logic                     launch;    // start honoured this edge
    logic                     advance;   // current window accepted, not the last
    logic [ADDR_W-1:0]        nxt_base, nxt_ch_base, tgt_base;
    logic [TAPS*ADDR_W-1:0]   addr_nxt;

    assign col_last = (out_col == COL_LAST);
    assign row_last = (out_row == ROW_LAST);
    assign ch_last  = (out_ch  == CH_LAST);
    assign win_last = col_last && row_last && ch_last;
    assign launch   = start && (state == S_IDLE || state == S_DONE);
    assign advance  = (state == S_RUN) && ready && !win_last;

    // Base of the window that follows the current one.
    always_comb begin
        nxt_ch_base = ch_base;
        nxt_base    = base + COL_STEP;
        if (col_last) begin
            nxt_base = base + ROW_STEP;
            if (row_last) begin
                nxt_ch_base = ch_base + PLANE;
                nxt_base    = nxt_ch_base;
            end
        end
    end

    // A new traversal always begins at window (0,0,0).
    assign tgt_base = launch ? '0 : nxt_base;

    for (genvar gi = 0; gi < POOL; gi++) begin : g_row
        for (genvar gj = 0; gj < POOL; gj++) begin : g_col
            pool_window_tap #(
                .ADDR_W (ADDR_W),
                .OFFSET (gi * IMG_W + gj)
            ) u_tap (
                .base (tgt_base),
                .tap  (addr_nxt[(gi*POOL+gj)*ADDR_W +: ADDR_W])
            );
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            lead_cnt <= '0;
            base     <= '0;
            ch_base  <= '0;
            addr     <= '0;
            valid    <= 1'b0;
            out_row  <= '0;
            out_col  <= '0;
            out_ch   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lead_cnt <= '0;
                        base     <= '0;
                        ch_base  <= '0;
                        addr     <= addr_nxt;
                        out_row  <= '0;
                        out_col  <= '0;
                        out_ch   <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        if (LEAD == 0) begin
                            state <= S_RUN;
                            valid <= 1'b1;
                        end else begin
                            state <= S_LEAD;
                            valid <= 1'b0;
                        end
                    end
                end

                // addr already holds window (0,0,0); just hold valid low.
                S_LEAD: begin
                    if (lead_cnt == LEAD_LAST) begin
                        state <= S_RUN;
                        valid <= 1'b1;
                    end else begin
                        lead_cnt <= lead_cnt + 4'd1;
                    end
                end

                S_RUN: begin
                    if (ready) begin
                        if (win_last) begin
                            state <= S_DONE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (advance) begin
                            base    <= nxt_base;
                            ch_base <= nxt_ch_base;
                            addr    <= addr_nxt;
                            if (col_last) begin
                                out_col <= '0;
                                if (row_last) begin
                                    out_row <= '0;
                                    out_ch  <= out_ch + CH_W'(1);
                                end else begin
                                    out_row <= out_row + ROW_W'(1);
                                end
                            end else begin
                                out_col <= out_col + COL_W'(1);
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_window_addr_gen.sv
module tb_pool_window_addr_gen;

    logic clk, reset;
    logic start0, ready0, start1, ready1, start2, ready2, start3, ready3;

    int checks   = 0;
    int failures = 0;

    // u0: 24x24 pool2 stride2, ADDR_W=10 (no wrap); u9: all defaults (ADDR_W=9, wraps)
    logic [39:0] a0;  logic v0, b0, d0; logic [3:0] r0, c0; logic [0:0] h0;
    logic [35:0] a9;  logic v9, b9, d9; logic [3:0] r9, c9; logic [0:0] h9;
    // u1: two channels
    logic [43:0] a1;  logic v1, b1, d1; logic [3:0] r1, c1; logic [1:0] h1;
    // u2: LEAD=3
    logic [39:0] a2;  logic v2, b2, d2; logic [3:0] r2, c2; logic [0:0] h2;
    // u3: 5x5 pool3 stride1
    logic [44:0] a3;  logic v3, b3, d3; logic [1:0] r3, c3; logic [0:0] h3;

    pool_window_addr_gen #(.ADDR_W(10)) u0 (
        .clk(clk), .reset(reset), .start(start0), .ready(ready0), .addr(a0), .valid(v0),
        .out_row(r0), .out_col(c0), .out_ch(h0), .busy(b0), .done(d0));

    pool_window_addr_gen u9 (
        .clk(clk), .reset(reset), .start(start0), .ready(ready0), .addr(a9), .valid(v9),
        .out_row(r9), .out_col(c9), .out_ch(h9), .busy(b9), .done(d9));

    pool_window_addr_gen #(.CHANNELS(2), .ADDR_W(11)) u1 (
        .clk(clk), .reset(reset), .start(start1), .ready(ready1), .addr(a1), .valid(v1),
        .out_row(r1), .out_col(c1), .out_ch(h1), .busy(b1), .done(d1));

    pool_window_addr_gen #(.LEAD(3), .ADDR_W(10)) u2 (
        .clk(clk), .reset(reset), .start(start2), .ready(ready2), .addr(a2), .valid(v2),
        .out_row(r2), .out_col(c2), .out_ch(h2), .busy(b2), .done(d2));

    pool_window_addr_gen #(.IMG_W(5), .IMG_H(5), .POOL(3), .STRIDE(1), .ADDR_W(5)) u3 (
        .clk(clk), .reset(reset), .start(start3), .ready(ready3), .addr(a3), .valid(v3),
        .out_row(r3), .out_col(c3), .out_ch(h3), .busy(b3), .done(d3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference window: taps packed tap k at [k*aw +: aw], addresses modulo 2^aw.
    function automatic logic [127:0] win(input int w, input int iw, input int ih,
                                         input int pool, input int stride, input int aw);
        int ow, oh, per, ch, r, c, a;
        logic [127:0] res;
        ow  = (iw - pool) / stride + 1;
        oh  = (ih - pool) / stride + 1;
        per = ow * oh;
        ch  = w / per;
        r   = (w % per) / ow;
        c   = w % ow;
        res = '0;
        for (int i = 0; i < pool; i++)
            for (int j = 0; j < pool; j++) begin
                a = (ch*iw*ih + (r*stride + i)*iw + c*stride + j) % (1 << aw);
                res = res | (128'(a) << ((i*pool + j)*aw));
            end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b0;
        start0 = 0; start1 = 0; start2 = 0; start3 = 0;
        ready0 = 1; ready1 = 1; ready2 = 0; ready3 = 1;
        repeat (2) tick;

        // ---- reset state
        chk("rst_addr", a0, '0);
        chk("rst_flags", {v0, b0, d0}, 3'b000);
        chk("rst_pos", {r0, c0, h0}, '0);
        chk("rst_flags_u3", {v3, b3, d3}, 3'b000);
        reset = 1'b1;
        tick;

        // ---- full default traversal with a 5-cycle stall at window 3
        start0 = 1; tick; start0 = 0;
        for (int w = 0; w < 144; w++) begin
            chk("u0_addr", a0, win(w, 24, 24, 2, 2, 10));
            chk("u9_addr", a9, win(w, 24, 24, 2, 2, 9));
            chk("u0_pos", {r0, c0}, {4'((w % 144) / 12), 4'(w % 12)});
            chk("u0_flags", {v0, b0, d0}, 3'b110);
            if (w == 0)   chk("u0_w0",   a0, {10'd25, 10'd24, 10'd1, 10'd0});
            if (w == 1)   chk("u0_w1",   a0, {10'd27, 10'd26, 10'd3, 10'd2});
            if (w == 4)   chk("u0_w4",   a0, {10'd33, 10'd32, 10'd9, 10'd8});
            if (w == 11)  chk("u0_w11",  a0, {10'd47, 10'd46, 10'd23, 10'd22});
            if (w == 12)  chk("u0_w12",  a0, {10'd73, 10'd72, 10'd49, 10'd48});
            if (w == 143) chk("u0_w143", a0, {10'd575, 10'd574, 10'd551, 10'd550});
            if (w == 143) chk("u9_w143_wrap", a9, {9'd63, 9'd62, 9'd39, 9'd38});
            if (w == 3) begin
                ready0 = 0;
                for (int s = 0; s < 5; s++) begin
                    tick;
                    chk("stall_addr", a0, {10'd31, 10'd30, 10'd7, 10'd6});
                    chk("stall_valid", v0, 1'b1);
                end
                ready0 = 1;
            end
            tick;
        end
        chk("u0_done", {v0, b0, d0}, 3'b001);
        chk("u9_done", {v9, b9, d9}, 3'b001);
        tick; tick;
        chk("u0_done_hold", {v0, b0, d0}, 3'b001);

        // ---- reset mid-traversal at window 50
        start0 = 1; tick; start0 = 0;
        chk("restart_w0", a0, {10'd25, 10'd24, 10'd1, 10'd0});
        chk("restart_flags", {v0, b0, d0}, 3'b110);
        for (int w = 0; w < 50; w++) begin
            chk("pre_rst_done", d0, 1'b0);
            tick;
        end
        chk("u0_w50", a0, win(50, 24, 24, 2, 2, 10));
        reset = 1'b0;
        #1;
        chk("midrst_addr", a0, '0);
        chk("midrst_flags", {v0, b0, d0}, 3'b000);
        chk("midrst_pos", {r0, c0, h0}, '0);
        tick;
        reset = 1'b1;
        tick;
        chk("post_rst_idle", {v0, b0, d0}, 3'b000);
        start0 = 1; tick; start0 = 0; ready0 = 0;
        chk("post_rst_w0", a0, {10'd25, 10'd24, 10'd1, 10'd0});
        chk("post_rst_flags", {v0, b0, d0}, 3'b110);

        // ---- two channels
        start1 = 1; tick; start1 = 0;
        for (int w = 0; w < 288; w++) begin
            chk("u1_addr", a1, win(w, 24, 24, 2, 2, 11));
            chk("u1_flags", {v1, b1, d1}, 3'b110);
            if (w == 144) begin
                chk("u1_w144", a1, {11'd601, 11'd600, 11'd577, 11'd576});
                chk("u1_w144_pos", {h1, r1, c1}, {2'd1, 4'd0, 4'd0});
            end
            if (w == 143) chk("u1_w143_ch", h1, 2'd0);
            tick;
        end
        chk("u1_done", {v1, b1, d1}, 3'b001);

        // ---- start-up latency of 3
        start2 = 1; tick; start2 = 0;
        chk("lead_e1", {v2, b2}, 2'b01);
        tick;
        chk("lead_e2", {v2, b2}, 2'b01);
        tick;
        chk("lead_e3", {v2, b2}, 2'b01);
        tick;
        chk("lead_run", {v2, b2, d2}, 3'b110);
        chk("lead_w0", a2, {10'd25, 10'd24, 10'd1, 10'd0});

        // ---- 3x3 window, stride 1, start during RUN ignored
        start3 = 1; tick; start3 = 0;
        for (int w = 0; w < 9; w++) begin
            start3 = 0;
            chk("u3_addr", a3, win(w, 5, 5, 3, 1, 5));
            chk("u3_flags", {v3, b3, d3}, 3'b110);
            if (w == 0)
                chk("u3_w0", a3, {5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd2, 5'd1, 5'd0});
            if (w == 3) chk("u3_w3_tap0", a3[4:0], 5'd5);
            if (w == 2) start3 = 1;
            tick;
        end
        start3 = 0;
        chk("u3_done", {v3, b3, d3}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
